// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: axis regions,
// standard HDMI mode timings and colour-bar palette.
package video_timing_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_t;

  // 1080p60 (CEA-861 VIC 16)
  localparam int MODE1080_H_ACTIVE = 1920;
  localparam int MODE1080_H_FP     = 88;
  localparam int MODE1080_H_SYNC   = 44;
  localparam int MODE1080_H_BP     = 148;
  localparam int MODE1080_V_ACTIVE = 1080;
  localparam int MODE1080_V_FP     = 4;
  localparam int MODE1080_V_SYNC   = 5;
  localparam int MODE1080_V_BP     = 36;

  // 720p60 (CEA-861 VIC 4)
  localparam int MODE720_H_ACTIVE = 1280;
  localparam int MODE720_H_FP     = 110;
  localparam int MODE720_H_SYNC   = 40;
  localparam int MODE720_H_BP     = 220;
  localparam int MODE720_V_ACTIVE = 720;
  localparam int MODE720_V_FP     = 5;
  localparam int MODE720_V_SYNC   = 5;
  localparam int MODE720_V_BP     = 20;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] barColour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: counts ACTIVE/FRONT/SYNC/BACK positions and flags the wrap.
// region describes the count this counter will hold after the coming edge.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = MODE1080_H_ACTIVE,
  parameter int FP     = MODE1080_H_FP,
  parameter int SYNC   = MODE1080_H_SYNC,
  parameter int BP     = MODE1080_H_BP,
  parameter int WIDTH  = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output region_t          region,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] FP_START   = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(ACTIVE + FP);
  localparam logic [WIDTH-1:0] BP_START   = WIDTH'(ACTIVE + FP + SYNC);

  logic [WIDTH-1:0] nextCount;

  assign wrap = (count == LAST);

  // Decoding the upcoming count lets the top register aligned outputs.
  always_comb begin
    nextCount = count;
    if (advance) nextCount = wrap ? '0 : count + WIDTH'(1);
    if (nextCount < FP_START)        region = REG_ACTIVE;
    else if (nextCount < SYNC_START) region = REG_FRONT;
    else if (nextCount < BP_START)   region = REG_SYNC;
    else                             region = REG_BACK;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) count <= LAST;
    else          count <= nextCount;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hSync/vSync/dataEnable, coordinates and strobes.
// Define VTG_PATTERN_EN to add the 8-bar colour test pattern output patternRgb.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE1080_H_ACTIVE,
  parameter int H_FP     = MODE1080_H_FP,
  parameter int H_SYNC   = MODE1080_H_SYNC,
  parameter int H_BP     = MODE1080_H_BP,
  parameter int V_ACTIVE = MODE1080_V_ACTIVE,
  parameter int V_FP     = MODE1080_V_FP,
  parameter int V_SYNC   = MODE1080_V_SYNC,
  parameter int V_BP     = MODE1080_V_BP,
  parameter int H_WIDTH  = 12,
  parameter int V_WIDTH  = 11,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  output logic               hSync,
  output logic               vSync,
  output logic               dataEnable,
  output logic [H_WIDTH-1:0] hCount,
  output logic [V_WIDTH-1:0] vCount,
  output logic               lineStart,
  output logic               frameStart
`ifdef VTG_PATTERN_EN
  ,
  output logic [23:0]        patternRgb
`endif
);

  region_t hRegion, vRegion;
  logic    hWrap, vWrap;
  logic    activeNext;

  timing_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .WIDTH(H_WIDTH)
  ) hAxis (
    .clock(clock), .reset_n(reset_n), .advance(enable),
    .count(hCount), .region(hRegion), .wrap(hWrap)
  );

  timing_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .WIDTH(V_WIDTH)
  ) vAxis (
    .clock(clock), .reset_n(reset_n), .advance(enable & hWrap),
    .count(vCount), .region(vRegion), .wrap(vWrap)
  );

  assign activeNext = (hRegion == REG_ACTIVE) && (vRegion == REG_ACTIVE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hSync      <= ~HS_POL;
      vSync      <= ~VS_POL;
      dataEnable <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (enable) begin
      hSync      <= (hRegion == REG_SYNC) ? HS_POL : ~HS_POL;
      vSync      <= (vRegion == REG_SYNC) ? VS_POL : ~VS_POL;
      dataEnable <= activeNext;
      lineStart  <= hWrap;
      frameStart <= hWrap & vWrap;
    end
  end

`ifdef VTG_PATTERN_EN
  logic [H_WIDTH-1:0] hNext;
  logic [2:0]         barNext;

  assign hNext = hWrap ? '0 : hCount + H_WIDTH'(1);

  // Bar index = hNext*8/H_ACTIVE, found by comparing against constant bar edges.
  always_comb begin
    barNext = '0;
    for (int unsigned k = 1; k < 8; k++)
      if (32'({hNext, 3'b000}) >= k * 32'(H_ACTIVE)) barNext = 3'(k);
  end

  always_ff @(posedge clock) begin
    if (!reset_n)    patternRgb <= '0;
    else if (enable) patternRgb <= activeNext ? barColour(barNext) : '0;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a tiny 15x8 raster, both sync polarities,
// against a linear-pixel-position reference model.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clock = 1'b0;
  logic resetN, enable;

  logic       hSyncP, vSyncP, deP, lineStartP, frameStartP;
  logic [3:0] hCountP;
  logic [2:0] vCountP;
  logic       hSyncN, vSyncN, deN, lineStartN, frameStartN;
  logic [3:0] hCountN;
  logic [2:0] vCountN;
`ifdef VTG_PATTERN_EN
  logic [23:0] rgbP, rgbN;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int pos;

  always #5 clock = ~clock;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_WIDTH(4), .V_WIDTH(3), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clock(clock), .reset_n(resetN), .enable(enable),
    .hSync(hSyncP), .vSync(vSyncP), .dataEnable(deP),
    .hCount(hCountP), .vCount(vCountP),
    .lineStart(lineStartP), .frameStart(frameStartP)
`ifdef VTG_PATTERN_EN
    , .patternRgb(rgbP)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_WIDTH(4), .V_WIDTH(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutNeg (
    .clock(clock), .reset_n(resetN), .enable(enable),
    .hSync(hSyncN), .vSync(vSyncN), .dataEnable(deN),
    .hCount(hCountN), .vCount(vCountN),
    .lineStart(lineStartN), .frameStart(frameStartN)
`ifdef VTG_PATTERN_EN
    , .patternRgb(rgbN)
`endif
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (pos %0d, t=%0t)", tag, observed, expected, pos, $time);
    end
  endtask

  task automatic checkAll();
    int  h, v;
    bit  de, hs, vs;
    h  = pos % HT;
    v  = pos / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HS);
    vs = (v >= VA + VF) && (v < VA + VF + VS);
    checkValue("hCount",     32'(hCountP),     32'(h));
    checkValue("vCount",     32'(vCountP),     32'(v));
    checkValue("hSync",      32'(hSyncP),      32'(hs));
    checkValue("vSync",      32'(vSyncP),      32'(vs));
    checkValue("dataEnable", 32'(deP),         32'(de));
    checkValue("lineStart",  32'(lineStartP),  32'(h == 0));
    checkValue("frameStart", 32'(frameStartP), 32'(pos == 0));
    checkValue("hSyncNeg",   32'(hSyncN),      32'(!hs));
    checkValue("vSyncNeg",   32'(vSyncN),      32'(!vs));
    checkValue("deNeg",      32'(deN),         32'(de));
    checkValue("hCountNeg",  32'(hCountN),     32'(h));
    checkValue("vCountNeg",  32'(vCountN),     32'(v));
`ifdef VTG_PATTERN_EN
    checkValue("patternRgb", 32'(rgbP), de ? 32'(BAR_RGB[h * 8 / HA]) : 32'd0);
    checkValue("patternNeg", 32'(rgbN), de ? 32'(BAR_RGB[h * 8 / HA]) : 32'd0);
`endif
  endtask

  // Drive inputs away from the edge, advance the model at the edge, sample 1 ns later.
  task automatic step(input logic rn, input logic en);
    resetN = rn;
    enable = en;
    @(posedge clock);
    if (!rn)     pos = FRAME - 1;
    else if (en) pos = (pos + 1) % FRAME;
    #1 checkAll();
  endtask

  task automatic goTo(input int target);
    for (int i = 0; i < FRAME && pos != target; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    resetN = 1'b0;
    enable = 1'b0;
    pos    = FRAME - 1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Release: first enabled edge is pixel (0,0), then two full frames and a bit.
    for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b1, 1'b1);

    // Hold mid-line at (3,2), then resume.
    goTo(2 * HT + 3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Hold while lineStart is high.
    goTo(3 * HT);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Hold on frameStart.
    goTo(0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Reset mid-frame at (9,6), with enable high.
    goTo(6 * HT + 9);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
